updown_counter: RTL and testbench

//   Loadable up/down modulo counter; the design end of counter_if. Samples rst/load/updown/data
//   on posedge clk and drives data_out plus registered wrap flags. Used as the DUT behind the

---
 rtl/updown_counter.sv | 88 ++++++++
 tb/tb_updown_counter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/updown_counter.sv
// Loadable up/down modulo counter with registered wrap pulses and direction.
// Define UDC_SATURATE_EN to hold at the limits instead of wrapping.
module updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_VAL   = (1 << WIDTH) - 1,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             updown,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] data_out,
  output logic             tc_up,
  output logic             tc_dn,
  output logic             dir
);

  typedef enum logic {DOWN = 1'b0, UP = 1'b1} dir_t;

  localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

  dir_t             state, state_nx;
  logic [WIDTH-1:0] cnt, cnt_nx;
  logic             up_nx, dn_nx;
  logic [WIDTH:0]   inc, dec;

  assign inc = {1'b0, cnt} + (WIDTH+1)'(1);
  assign dec = {1'b0, cnt} - (WIDTH+1)'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= UP;
      cnt   <= RST_V;
      tc_up <= 1'b0;
      tc_dn <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      tc_up <= up_nx;
      tc_dn <= dn_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    up_nx    = 1'b0;
    dn_nx    = 1'b0;
    if (load) begin
      cnt_nx = ({1'b0, data} > MAX_W) ? MAX_V : data;
    end else if (updown) begin
      state_nx = UP;
      if (cnt == MAX_V) begin
        up_nx = 1'b1;
`ifdef UDC_SATURATE_EN
        cnt_nx = MAX_V;
`else
        cnt_nx = '0;
`endif
      end else begin
        cnt_nx = inc[WIDTH-1:0];
      end
    end else begin
      state_nx = DOWN;
      if (cnt == '0) begin
        dn_nx = 1'b1;
`ifdef UDC_SATURATE_EN
        cnt_nx = '0;
`else
        cnt_nx = MAX_V;
`endif
      end else begin
        cnt_nx = dec[WIDTH-1:0];
      end
    end
  end

  assign data_out = cnt;
  assign dir      = (state == UP);

  // Control inputs must be known whenever the counter is running.
  a_no_x: assert property (@(posedge clk) disable iff (rst)
    !$isunknown({load, updown}));

endmodule

// File: tb/tb_updown_counter.sv
// Directed table-driven bench for updown_counter (full-range and MAX_VAL=9).
module tb_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic       updown = 1'b1;
  logic [3:0] data = '0;
  logic [3:0] q, q9;
  logic       tu, td, dr, tu9, td9, dr9;

  int tests = 0;
  int fails = 0;

  updown_counter #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .load(load), .updown(updown), .data(data),
    .data_out(q), .tc_up(tu), .tc_dn(td), .dir(dr)
  );

  updown_counter #(.WIDTH(4), .MAX_VAL(9)) dut9 (
    .clk(clk), .rst(rst), .load(load), .updown(updown), .data(data),
    .data_out(q9), .tc_up(tu9), .tc_dn(td9), .dir(dr9)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       load;
    logic       updown;
    logic [3:0] data;
    logic [6:0] exp;
  } vec_t;

  vec_t vec [16];

  function automatic logic [6:0] ex(input logic [3:0] v, input logic u,
                                    input logic d, input logic r);
    return {v, u, d, r};
  endfunction

  task automatic check(input string name, input logic [6:0] act,
                       input logic [6:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got q=%h up=%b dn=%b dir=%b, want q=%h up=%b dn=%b dir=%b",
               name, act[6:3], act[2], act[1], act[0],
               exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic step(input logic r, input logic l, input logic u,
                      input logic [3:0] d);
    @(negedge clk);
    rst = r; load = l; updown = u; data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec[0]  = '{1, 0, 1, 4'h0, ex(4'h0, 0, 0, 1)};
    vec[1]  = '{0, 1, 1, 4'hA, ex(4'hA, 0, 0, 1)};
    vec[2]  = '{0, 0, 1, 4'h0, ex(4'hB, 0, 0, 1)};
    vec[3]  = '{0, 0, 1, 4'h0, ex(4'hC, 0, 0, 1)};
    vec[4]  = '{0, 0, 1, 4'h0, ex(4'hD, 0, 0, 1)};
    vec[5]  = '{0, 0, 1, 4'h0, ex(4'hE, 0, 0, 1)};
    vec[6]  = '{0, 0, 1, 4'h0, ex(4'hF, 0, 0, 1)};
`ifdef UDC_SATURATE_EN
    vec[7]  = '{0, 0, 1, 4'h0, ex(4'hF, 1, 0, 1)};
    vec[8]  = '{0, 0, 1, 4'h0, ex(4'hF, 1, 0, 1)};
`else
    vec[7]  = '{0, 0, 1, 4'h0, ex(4'h0, 1, 0, 1)};
    vec[8]  = '{0, 0, 1, 4'h0, ex(4'h1, 0, 0, 1)};
`endif
    vec[9]  = '{0, 1, 0, 4'h1, ex(4'h1, 0, 0, 1)};
    vec[10] = '{0, 0, 0, 4'h0, ex(4'h0, 0, 0, 0)};
`ifdef UDC_SATURATE_EN
    vec[11] = '{0, 0, 0, 4'h0, ex(4'h0, 0, 1, 0)};
    vec[12] = '{0, 0, 0, 4'h0, ex(4'h0, 0, 1, 0)};
    vec[13] = '{0, 0, 1, 4'h0, ex(4'h1, 0, 0, 1)};
`else
    vec[11] = '{0, 0, 0, 4'h0, ex(4'hF, 0, 1, 0)};
    vec[12] = '{0, 0, 0, 4'h0, ex(4'hE, 0, 0, 0)};
    vec[13] = '{0, 0, 1, 4'h0, ex(4'hF, 0, 0, 1)};
`endif
    vec[14] = '{0, 1, 0, 4'h3, ex(4'h3, 0, 0, 1)};
    vec[15] = '{0, 1, 1, 4'h3, ex(4'h3, 0, 0, 1)};

    for (int i = 0; i < 16; i++) begin
      step(vec[i].rst, vec[i].load, vec[i].updown, vec[i].data);
      check($sformatf("vec%0d", i), {q, tu, td, dr}, vec[i].exp);
    end

    // Asynchronous reset mid-count, between edges.
    step(0, 1, 1, 4'hA);
    step(0, 0, 0, 4'h0);
    check("pre_rst", {q, tu, td, dr}, ex(4'h9, 0, 0, 0));
    #2 rst = 1'b1;
    #1;
    check("async_rst", {q, tu, td, dr}, ex(4'h0, 0, 0, 1));
    @(posedge clk);
    #1;
    check("rst_held", {q, tu, td, dr}, ex(4'h0, 0, 0, 1));
    step(0, 0, 1, 4'h0);
    check("rst_release", {q, tu, td, dr}, ex(4'h1, 0, 0, 1));

    // MAX_VAL=9 instance: clamp on load, then limit behaviour.
    step(0, 1, 1, 4'hC);
    check("m9_clamp", {q9, tu9, td9, dr9}, ex(4'h9, 0, 0, 1));
    step(0, 0, 1, 4'h0);
`ifdef UDC_SATURATE_EN
    check("m9_up", {q9, tu9, td9, dr9}, ex(4'h9, 1, 0, 1));
    step(0, 0, 0, 4'h0);
    check("m9_dn", {q9, tu9, td9, dr9}, ex(4'h8, 0, 0, 0));
`else
    check("m9_up", {q9, tu9, td9, dr9}, ex(4'h0, 1, 0, 1));
    step(0, 0, 0, 4'h0);
    check("m9_dn", {q9, tu9, td9, dr9}, ex(4'h9, 0, 1, 0));
`endif
    step(0, 1, 1, 4'h8);
    step(0, 0, 1, 4'h0);
    check("m9_to_max", {q9, tu9, td9, dr9}, ex(4'h9, 0, 0, 1));

`ifdef UDC_SATURATE_EN
    step(0, 1, 1, 4'hE);
    step(0, 0, 1, 4'h0);
    check("sat_up1", {q, tu, td, dr}, ex(4'hF, 0, 0, 1));
    step(0, 0, 1, 4'h0);
    check("sat_up2", {q, tu, td, dr}, ex(4'hF, 1, 0, 1));
    step(0, 0, 1, 4'h0);
    check("sat_up3", {q, tu, td, dr}, ex(4'hF, 1, 0, 1));
    step(0, 1, 0, 4'h0);
    step(0, 0, 0, 4'h0);
    check("sat_dn0", {q, tu, td, dr}, ex(4'h0, 0, 1, 0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
